// File: rtl/c_diag_axis_packer.sv
// Buffers result diagonals from the systolic core in a small FIFO and serializes
// each one into AXI-Stream beats, with tlast on the final beat of every matrix.
module c_diag_axis_packer #(
  parameter int SIZE                   = 4,
  parameter int O_BITS                 = 16,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH             = 8
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_valid,
  input  logic [SIZE*O_BITS-1:0]              i_c_diag,
  output logic                                m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]         o_fifo_level,
  output logic                                o_overflow,
  output logic                                o_frame_done
);
  localparam int DW    = SIZE * O_BITS;
  localparam int TW    = C_M00_AXIS_TDATA_WIDTH;
  localparam int BEATS = DW / TW;
  localparam int DIAGS = 2 * SIZE - 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = (DIAGS > 1) ? $clog2(DIAGS) : 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [CW-1:0] DIAG_LAST = CW'(DIAGS - 1);
  localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic [DW-1:0] r_shift;
  logic [BW-1:0] r_beat_cnt;
  logic [CW-1:0] r_diag_cnt;
  logic          r_tvalid, r_overflow, r_frame_done;
  state_t        r_state;

  logic w_hs, w_word_end, w_pop, w_push, w_tlast;

  always_comb begin
    w_hs       = r_tvalid & m00_axis_tready;
    w_word_end = w_hs & (r_beat_cnt == BEAT_LAST);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    w_pop      = (r_level != '0) & ((r_state == S_IDLE) | w_word_end);
    w_push     = i_valid & ((r_level != LVL_FULL) | w_pop);
    w_tlast    = r_tvalid & (r_diag_cnt == DIAG_LAST) & (r_beat_cnt == BEAT_LAST);
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_c_diag;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_shift      <= '0;
      r_beat_cnt   <= '0;
      r_diag_cnt   <= '0;
      r_tvalid     <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_state      <= S_IDLE;
    end else begin
      r_frame_done <= w_hs & w_tlast;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (i_valid & ~w_push) r_overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_tvalid <= 1'b1;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            if (r_beat_cnt == BEAT_LAST) begin
              r_beat_cnt <= '0;
              r_diag_cnt <= (r_diag_cnt == DIAG_LAST) ? '0 : r_diag_cnt + 1'b1;
              // Chain straight into the next word when one is waiting: no bubble.
              if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
              end else begin
                r_shift  <= '0;
                r_tvalid <= 1'b0;
                r_state  <= S_IDLE;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
              r_shift    <= r_shift >> TW;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tdata  = r_shift[TW-1:0];
  assign m00_axis_tstrb  = {(TW/8){r_tvalid}};
  assign m00_axis_tlast  = w_tlast;
  assign o_fifo_level    = r_level;
  assign o_overflow      = r_overflow;
  assign o_frame_done    = r_frame_done;

endmodule
